apb_cmd_master: RTL and testbench

APB_CMD_MASTER -- requirements
Module: apb_cmd_master

---
 rtl/apb_pkg.sv | 30 +++
 rtl/apb_cmd_master_if.sv | 59 +++++
 rtl/apb_cmd_master.sv | 115 +++++++++++
 tb/tb_apb_cmd_master.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB types: transfer FSM states and PPROT bit positions
//
// Contents:
//   apb_state_t   command-master transfer states (IDLE, SETUP, ACCESS, RESP)
//   PPROT_*       bit index of each PPROT attribute
//   pprot_pack    builds a PPROT vector from its three attribute flags
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_t;

  localparam int PPROT_PRIV   = 0;
  localparam int PPROT_NONSEC = 1;
  localparam int PPROT_INSTR  = 2;

  function automatic logic [2:0] pprot_pack(input logic priv, input logic nonsec,
                                            input logic instr);
    logic [2:0] p;
    p               = '0;
    p[PPROT_PRIV]   = priv;
    p[PPROT_NONSEC] = nonsec;
    p[PPROT_INSTR]  = instr;
    return p;
  endfunction

endpackage

// File: rtl/apb_cmd_master_if.sv
// rtl/apb_cmd_master_if.sv - command, response and APB master signal bundle
//
// Parameters: G_REGWIDTH (data width, multiple of 8), G_ADDR_WIDTH (address width)
// Groups:
//   cmd_*    command in  (valid/ready handshake, write, prot, addr, wdata, strb)
//   rsp_*    response out (valid/ready handshake, rdata, slverr, timeout)
//   m_apb_*  APB master bus
// Modports: master = the command master block, slave = its environment
interface apb_cmd_master_if #(
  parameter int G_REGWIDTH   = 32,
  parameter int G_ADDR_WIDTH = 32
);

  logic                      cmd_valid;
  logic                      cmd_ready;
  logic                      cmd_write;
  logic [2:0]                cmd_prot;
  logic [G_ADDR_WIDTH-1:0]   cmd_addr;
  logic [G_REGWIDTH-1:0]     cmd_wdata;
  logic [G_REGWIDTH/8-1:0]   cmd_strb;

  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [G_REGWIDTH-1:0]     rsp_rdata;
  logic                      rsp_slverr;
  logic                      rsp_timeout;

  logic                      m_apb_psel;
  logic                      m_apb_penable;
  logic                      m_apb_pwrite;
  logic [2:0]                m_apb_pprot;
  logic [G_ADDR_WIDTH-1:0]   m_apb_paddr;
  logic [G_REGWIDTH-1:0]     m_apb_pwdata;
  logic [G_REGWIDTH/8-1:0]   m_apb_pstrb;
  logic                      m_apb_pready;
  logic [G_REGWIDTH-1:0]     m_apb_prdata;
  logic                      m_apb_pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_prot, cmd_addr, cmd_wdata, cmd_strb,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
    input  rsp_ready,
    output m_apb_psel, m_apb_penable, m_apb_pwrite, m_apb_pprot, m_apb_paddr,
           m_apb_pwdata, m_apb_pstrb,
    input  m_apb_pready, m_apb_prdata, m_apb_pslverr
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_prot, cmd_addr, cmd_wdata, cmd_strb,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
    output rsp_ready,
    input  m_apb_psel, m_apb_penable, m_apb_pwrite, m_apb_pprot, m_apb_paddr,
           m_apb_pwdata, m_apb_pstrb,
    output m_apb_pready, m_apb_prdata, m_apb_pslverr
  );

endinterface

// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - single-command APB master with wait-state timeout
//
// Turns one command into one APB transfer and returns one response.
// Parameters: G_REGWIDTH, G_ADDR_WIDTH, G_TIMEOUT (max ACCESS cycles, 0 = no limit)
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  apb_cmd_master_if.master: cmd_* in, rsp_* out, m_apb_* APB master
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int G_REGWIDTH   = 32,
  parameter int G_ADDR_WIDTH = 32,
  parameter int G_TIMEOUT    = 16
) (
  input  logic                clk,
  input  logic                rst,
  apb_cmd_master_if.master    bus
);

  localparam int STRB_W = G_REGWIDTH / 8;
  // A zero-width counter is illegal, so the disabled-timeout build keeps one bit.
  localparam int CNT_W = (G_TIMEOUT > 0) ? $clog2(G_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((G_TIMEOUT > 0) ? G_TIMEOUT - 1 : 0);

  apb_state_t state, state_next;

  logic                    pwrite_q;
  logic [2:0]              pprot_q;
  logic [G_ADDR_WIDTH-1:0] paddr_q;
  logic [G_REGWIDTH-1:0]   pwdata_q;
  logic [STRB_W-1:0]       pstrb_q;
  logic [G_REGWIDTH-1:0]   rdata_q;
  logic                    slverr_q;
  logic                    timeout_q;
  logic [CNT_W-1:0]        wait_cnt;
  logic                    timeout_hit;

  // Abort on the last permitted ACCESS cycle only if the slave is still stalling;
  // a pready arriving on that same cycle completes the transfer normally.
  assign timeout_hit = (G_TIMEOUT > 0) && (wait_cnt == CNT_LAST) && !bus.m_apb_pready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (bus.cmd_valid) state_next = ST_SETUP;
      ST_SETUP:  state_next = ST_ACCESS;
      ST_ACCESS: if (bus.m_apb_pready || timeout_hit) state_next = ST_RESP;
      ST_RESP:   if (bus.rsp_ready) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwrite_q  <= 1'b0;
      pprot_q   <= '0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      rdata_q   <= '0;
      slverr_q  <= 1'b0;
      timeout_q <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            pwrite_q <= bus.cmd_write;
            pprot_q  <= bus.cmd_prot;
            paddr_q  <= bus.cmd_addr;
            // Reads present zero data and strobes on the bus.
            pwdata_q <= bus.cmd_write ? bus.cmd_wdata : '0;
            pstrb_q  <= bus.cmd_write ? bus.cmd_strb : '0;
          end
        end
        ST_SETUP: wait_cnt <= '0;
        ST_ACCESS: begin
          if (bus.m_apb_pready) begin
            rdata_q   <= pwrite_q ? '0 : bus.m_apb_prdata;
            slverr_q  <= bus.m_apb_pslverr;
            timeout_q <= 1'b0;
          end else if (timeout_hit) begin
            rdata_q   <= '0;
            slverr_q  <= 1'b1;
            timeout_q <= 1'b1;
          end else if (wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready     = (state == ST_IDLE);
  assign bus.rsp_valid     = (state == ST_RESP);
  assign bus.rsp_rdata     = rdata_q;
  assign bus.rsp_slverr    = slverr_q;
  assign bus.rsp_timeout   = timeout_q;
  assign bus.m_apb_psel    = (state == ST_SETUP) || (state == ST_ACCESS);
  assign bus.m_apb_penable = (state == ST_ACCESS);
  assign bus.m_apb_pwrite  = pwrite_q;
  assign bus.m_apb_pprot   = pprot_q;
  assign bus.m_apb_paddr   = paddr_q;
  assign bus.m_apb_pwdata  = pwdata_q;
  assign bus.m_apb_pstrb   = pstrb_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb/tb_apb_cmd_master.sv - self-checking bench for apb_cmd_master
module tb_apb_cmd_master;
  import apb_pkg::*;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  apb_cmd_master_if #(.G_REGWIDTH(32), .G_ADDR_WIDTH(32)) bus ();

  apb_cmd_master #(.G_REGWIDTH(32), .G_ADDR_WIDTH(32), .G_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
    chk({tag, "_rsp_slverr"}, bus.rsp_slverr, 0);
    chk({tag, "_rsp_timeout"}, bus.rsp_timeout, 0);
    chk({tag, "_psel"}, bus.m_apb_psel, 0);
    chk({tag, "_penable"}, bus.m_apb_penable, 0);
    chk({tag, "_pwrite"}, bus.m_apb_pwrite, 0);
    chk({tag, "_pprot"}, bus.m_apb_pprot, 0);
    chk({tag, "_paddr"}, bus.m_apb_paddr, 0);
    chk({tag, "_pwdata"}, bus.m_apb_pwdata, 0);
    chk({tag, "_pstrb"}, bus.m_apb_pstrb, 0);
  endtask

  task automatic junk_cmd_fields();
    bus.cmd_write = 1'($urandom);
    bus.cmd_prot  = 3'($urandom);
    bus.cmd_addr  = $urandom;
    bus.cmd_wdata = $urandom;
    bus.cmd_strb  = 4'($urandom);
  endtask

  task automatic junk_apb_inputs();
    bus.m_apb_pready  = 1'($urandom);
    bus.m_apb_pslverr = 1'($urandom);
    bus.m_apb_prdata  = $urandom;
  endtask

  // One complete transfer, entered and left on a falling edge with the DUT idle.
  // waits = stalled ACCESS cycles the slave inserts before pready; bp = cycles of
  // response backpressure; junk = offer another command while backpressured.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [2:0] prot, input int waits,
                      input logic [31:0] rdata_v, input logic serr, input int bp,
                      input logic junk);
    logic        timed_out;
    int          ncyc;
    logic [31:0] exp_pw, exp_rd;
    logic [3:0]  exp_ps;
    logic        exp_se;

    // Reference: the slave gets waits+1 ACCESS cycles unless that exceeds TO.
    timed_out = (TO > 0) && (waits >= TO);
    ncyc      = timed_out ? TO : waits + 1;
    exp_pw    = wr ? wdata : 32'h0;
    exp_ps    = wr ? strb : 4'h0;
    exp_rd    = (timed_out || wr) ? 32'h0 : rdata_v;
    exp_se    = timed_out ? 1'b1 : serr;

    chk("idle_cmd_ready", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_strb  = strb;
    bus.cmd_prot  = prot;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    junk_cmd_fields();

    chk("setup_psel", bus.m_apb_psel, 1);
    chk("setup_penable", bus.m_apb_penable, 0);
    chk("setup_cmd_ready", bus.cmd_ready, 0);
    chk("setup_pwrite", bus.m_apb_pwrite, wr);
    chk("setup_paddr", bus.m_apb_paddr, addr);
    chk("setup_pprot", bus.m_apb_pprot, prot);
    chk("setup_pwdata", bus.m_apb_pwdata, exp_pw);
    chk("setup_pstrb", bus.m_apb_pstrb, exp_ps);
    junk_apb_inputs();

    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      chk("access_psel", bus.m_apb_psel, 1);
      chk("access_penable", bus.m_apb_penable, 1);
      chk("access_paddr", bus.m_apb_paddr, addr);
      chk("access_pwrite", bus.m_apb_pwrite, wr);
      chk("access_pprot", bus.m_apb_pprot, prot);
      chk("access_pwdata", bus.m_apb_pwdata, exp_pw);
      chk("access_pstrb", bus.m_apb_pstrb, exp_ps);
      if (n == waits + 1) begin
        bus.m_apb_pready  = 1'b1;
        bus.m_apb_prdata  = rdata_v;
        bus.m_apb_pslverr = serr;
      end else begin
        bus.m_apb_pready  = 1'b0;
        bus.m_apb_prdata  = $urandom;
        bus.m_apb_pslverr = 1'($urandom);
      end
    end
    @(negedge clk);
    junk_apb_inputs();

    for (int k = 0; k <= bp; k++) begin
      chk("rsp_valid", bus.rsp_valid, 1);
      chk("rsp_rdata", bus.rsp_rdata, exp_rd);
      chk("rsp_slverr", bus.rsp_slverr, exp_se);
      chk("rsp_timeout", bus.rsp_timeout, timed_out);
      chk("rsp_psel", bus.m_apb_psel, 0);
      chk("rsp_penable", bus.m_apb_penable, 0);
      chk("rsp_cmd_ready", bus.cmd_ready, 0);
      if (k == bp) begin
        bus.rsp_ready = 1'b1;
        bus.cmd_valid = 1'b0;
      end else begin
        bus.rsp_ready = 1'b0;
        bus.cmd_valid = junk;
        junk_cmd_fields();
      end
      junk_apb_inputs();
      @(negedge clk);
    end
    bus.rsp_ready = 1'b0;
    bus.m_apb_pready = 1'b0;
    chk("done_rsp_valid", bus.rsp_valid, 0);
    chk("done_psel", bus.m_apb_psel, 0);
  endtask

  initial begin
    rst               = 1'b1;
    bus.cmd_valid     = 1'b0;
    bus.cmd_write     = 1'b0;
    bus.cmd_prot      = '0;
    bus.cmd_addr      = '0;
    bus.cmd_wdata     = '0;
    bus.cmd_strb      = '0;
    bus.rsp_ready     = 1'b0;
    bus.m_apb_pready  = 1'b0;
    bus.m_apb_prdata  = '0;
    bus.m_apb_pslverr = 1'b0;

    #3;
    chk_reset_values("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Zero-wait write: SETUP at accept+1, ACCESS at accept+2, response at accept+3.
    xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, pprot_pack(1'b1, 1'b0, 1'b0), 0, 32'h0, 1'b0, 0, 1'b0);
    // Read with three wait states.
    xfer(1'b0, 32'h20, 32'hFFFF_FFFF, 4'hF, pprot_pack(1'b0, 1'b1, 1'b0), 3, 32'h12345678, 1'b0, 0, 1'b0);
    // Slave error on a read.
    xfer(1'b0, 32'h30, 32'h0, 4'h0, pprot_pack(1'b0, 1'b0, 1'b1), 0, 32'hCAFEF00D, 1'b1, 0, 1'b0);
    // Slave never ready: abort after TO ACCESS cycles.
    xfer(1'b0, 32'h40, 32'h0, 4'h0, 3'h0, 100, 32'hBAD0BAD0, 1'b0, 0, 1'b0);
    // pready on the last allowed ACCESS cycle beats the timeout.
    xfer(1'b1, 32'h44, 32'h55AA55AA, 4'h5, 3'h7, TO - 1, 32'h0, 1'b0, 0, 1'b0);
    xfer(1'b0, 32'h48, 32'h0, 4'h0, 3'h2, TO - 1, 32'h0BADCAFE, 1'b0, 0, 1'b0);
    // Response backpressure with a competing command on the bus.
    xfer(1'b1, 32'h50, 32'h01234567, 4'h3, 3'h1, 1, 32'h0, 1'b1, 5, 1'b1);

    // Reset in the middle of an ACCESS cycle.
    chk("mid_rst_idle", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'hABCD;
    bus.cmd_wdata = 32'h11112222;
    bus.cmd_strb  = 4'hF;
    bus.cmd_prot  = 3'h5;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    bus.m_apb_pready = 1'b0;
    chk("mid_rst_in_access", bus.m_apb_penable, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_psel", bus.m_apb_psel, 0);
    chk("async_rst_penable", bus.m_apb_penable, 0);
    chk("async_rst_rsp_valid", bus.rsp_valid, 0);
    chk("async_rst_cmd_ready", bus.cmd_ready, 1);
    @(negedge clk);
    chk_reset_values("mid_rst");
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", bus.rsp_valid, 0);
    end
    bus.rsp_ready = 1'b0;
    xfer(1'b0, 32'h60, 32'h0, 4'h0, 3'h0, 2, 32'h89ABCDEF, 1'b0, 1, 1'b0);

    // Randomised transfers, including timeouts and backpressure.
    for (int t = 0; t < 40; t++) begin
      xfer(1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom),
           int'($urandom_range(0, TO + 1)), $urandom, 1'($urandom),
           int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
